// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, ALU select encodings and instruction-word field layout
// for the accumulator CPU datapath (sync_ram_large, alu and the controller).
package cpu_pkg;

    // Default memory geometry: 16K words of 32 bits.
    localparam int ADDR_WIDTH_DEF = 14;
    localparam int DATA_WIDTH_DEF = 32;

    // ALU select encodings consumed by the sibling alu block.
    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_ADD = 3'b001,
        ALU_SUB = 3'b010,
        ALU_OR  = 3'b100
    } alu_sel_e;

    // Instruction word layout: IR[31] mode, IR[30:27] opcode, IR[26:0] operand.
    localparam int IR_MODE_BIT = 31;
    localparam int IR_OP_MSB   = 30;
    localparam int IR_OP_LSB   = 27;
    localparam int IR_OPND_MSB = 26;
    localparam int IR_OPND_LSB = 0;
    localparam int IR_OP_W     = IR_OP_MSB - IR_OP_LSB + 1;
    localparam int IR_OPND_W   = IR_OPND_MSB - IR_OPND_LSB + 1;

    typedef struct packed {
        logic                 mode;
        logic [IR_OP_W-1:0]   opcode;
        logic [IR_OPND_W-1:0] operand;
    } ir_t;

    // Split a fetched word into its instruction fields.
    function automatic ir_t ir_decode(input logic [DATA_WIDTH_DEF-1:0] word);
        ir_t ir;
        ir.mode    = word[IR_MODE_BIT];
        ir.opcode  = word[IR_OP_MSB:IR_OP_LSB];
        ir.operand = word[IR_OPND_MSB:IR_OPND_LSB];
        return ir;
    endfunction

    // Reassemble an instruction word from its fields.
    function automatic logic [DATA_WIDTH_DEF-1:0] ir_encode(input ir_t ir);
        return {ir.mode, ir.opcode, ir.operand};
    endfunction

endpackage

// File: rtl/ram_bus_if.sv
// ram_bus_if: enable decode and tristate driver for the shared memory data bus.
//   rst_n   in     async active-low reset; low forces release and blocks writes
//   cs      in     chip select, active high
//   we      in     write enable, active high (wins over oe)
//   oe      in     output enable, active high
//   rdata   in     word currently addressed in the array
//   data    inout  shared bus; driven with rdata only while read_en is high
//   read_en out    bus is being driven by the memory
//   write_en out   array captures the bus on the next rising edge
module ram_bus_if
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  rst_n,
    input  logic                  cs,
    input  logic                  we,
    input  logic                  oe,
    input  logic [DATA_WIDTH-1:0] rdata,
    inout  wire  [DATA_WIDTH-1:0] data,
    output logic                  read_en,
    output logic                  write_en
);

    // read_en and write_en are mutually exclusive through we, so the memory
    // never drives the bus in a cycle where it samples it.
    assign write_en = rst_n & cs & we;
    assign read_en  = rst_n & cs & ~we & oe;

    assign data = read_en ? rdata : {DATA_WIDTH{1'bz}};

endmodule

// File: rtl/sync_ram_large.sv
// sync_ram_large: single-port word memory with synchronous write and combinational
// read over one shared bidirectional bus; unified instruction/data store.
//   clk      in     rising-edge clock for writes
//   rst_n    in     async active-low reset; releases bus, blocks writes
//   addr     in     word index, full 2**ADDR_WIDTH address space
//   data     inout  shared data bus
//   cs_input in     chip select, active high
//   we       in     write enable, active high
//   oe       in     output enable, active high
module sync_ram_large
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] addr,
    inout  wire  [DATA_WIDTH-1:0] data,
    input  logic                  cs_input,
    input  logic                  we,
    input  logic                  oe
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Contents are deliberately not reset so the array maps onto block RAM.
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata;
    logic                  read_en;
    logic                  write_en;

    assign rdata = mem[addr];

    ram_bus_if #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_bus (
        .rst_n   (rst_n),
        .cs      (cs_input),
        .we      (we),
        .oe      (oe),
        .rdata   (rdata),
        .data    (data),
        .read_en (read_en),
        .write_en(write_en)
    );

    // An unknown write_en (X on cs_input/we) falls through the if, so no write.
    always_ff @(posedge clk) begin
        if (write_en) mem[addr] <= data;
    end

    a_ctrl_known: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown({cs_input, we}));

endmodule

// File: tb/tb_sync_ram_large.sv
// tb_sync_ram_large: scoreboard bench for sync_ram_large read/write/bus-release behaviour.
module tb_sync_ram_large;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] addr;
    logic        cs_input;
    logic        we;
    logic        oe;
    logic [31:0] drv;
    logic        drv_en;
    wire  [31:0] data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic        rel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    logic [31:0] wtab [18] = '{
        32'h1000011E, 32'h00000120, 32'h1800011C, 32'h20000124, 32'h28000126, 32'h08000128,
        32'h3000012A, 32'h0000012C, 32'h38000122, 32'h4000012E, 32'h48000130, 32'h50000132,
        32'h58000134, 32'h60000136, 32'h68000138, 32'h7000013A, 32'h7800013C, 32'h0000013E
    };

    assign data = drv_en ? drv : {32{1'bz}};

    sync_ram_large dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr    (addr),
        .data    (data),
        .cs_input(cs_input),
        .we      (we),
        .oe      (oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Released bus reads as Z in four-state simulators and as 0 in two-state ones;
    // every stored word used here is non-zero, so a driven bus is still detected.
    function automatic logic released();
        return (data === {32{1'bz}}) || (data === 32'h0);
    endfunction

    always @(negedge clk) begin
        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.rel) check(e.tag, {31'b0, released()}, 32'd1);
            else       check(e.tag, data, e.val);
        end
    end

    task automatic wr(input logic [13:0] a, input logic [31:0] v);
        @(posedge clk); #1;
        addr = a; cs_input = 1'b1; we = 1'b1; oe = 1'b0; drv = v; drv_en = 1'b1;
    endtask

    task automatic rd(input string tag, input logic [13:0] a, input logic [31:0] v);
        @(posedge clk); #1;
        addr = a; cs_input = 1'b1; we = 1'b0; oe = 1'b1; drv_en = 1'b0;
        sb.push_back('{tag, 1'b0, v});
    endtask

    task automatic idle(input string tag, input logic c, input logic w, input logic o);
        @(posedge clk); #1;
        addr = 14'h100; cs_input = c; we = w; oe = o; drv_en = 1'b0;
        sb.push_back('{tag, 1'b1, 32'h0});
    endtask

    initial begin
        rst_n = 1'b0; cs_input = 1'b1; we = 1'b0; oe = 1'b1; addr = 14'h100;
        drv = 32'h0; drv_en = 1'b0;
        #3;
        check("reset_release", {31'b0, released()}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1; oe = 1'b0;

        wr(14'h100, 32'h1000011E);
        wr(14'h102, 32'h00000120);
        rd("rd_100", 14'h100, 32'h1000011E);
        rd("rd_102", 14'h102, 32'h00000120);

        for (int i = 0; i < 18; i++) wr(14'(14'h100 + 2 * i), wtab[i]);
        for (int i = 0; i < 18; i++) rd($sformatf("b2b_%0d", i), 14'(14'h100 + 2 * i), wtab[i]);

        @(posedge clk); #1;
        addr = 14'h100; cs_input = 1'b1; we = 1'b0; oe = 1'b1; drv_en = 1'b0;
        #2 addr = 14'h102;
        sb.push_back('{"addr_track", 1'b0, 32'h00000120});

        idle("rel_oe0", 1'b1, 1'b0, 1'b0);
        idle("rel_cs0", 1'b0, 1'b0, 1'b1);

        @(posedge clk); #1;
        addr = 14'h100; cs_input = 1'b1; we = 1'b1; oe = 1'b1; drv = 32'hCAFEF00D; drv_en = 1'b1;
        #1 check("we_oe_no_drive", {31'b0, dut.u_bus.read_en}, 32'd0);
        sb.push_back('{"we_oe_bus", 1'b0, 32'hCAFEF00D});
        rd("we_oe_written", 14'h100, 32'hCAFEF00D);

        @(posedge clk); #1;
        addr = 14'h104; cs_input = 1'b0; we = 1'b1; oe = 1'b0; drv = 32'hDEADBEEF; drv_en = 1'b1;
        rd("cs0_no_write", 14'h104, 32'h1800011C);

        @(posedge clk); #1;
        addr = 14'h110; cs_input = 1'b1; we = 1'b0; oe = 1'b1; drv_en = 1'b0;
        #1 check("pre_reset_rd", data, 32'h38000122);
        rst_n = 1'b0;
        #1 check("reset_async_rel", {31'b0, released()}, 32'd1);
        wr(14'h110, 32'h12345678);
        @(posedge clk); #1;
        drv_en = 1'b0; we = 1'b0; oe = 1'b0; rst_n = 1'b1;
        rd("reset_no_write", 14'h110, 32'h38000122);

        @(posedge clk); #1;
        addr = 14'h11E; cs_input = 1'b1; we = 1'b0; oe = 1'b0; drv_en = 1'b0;
        @(posedge clk); #1;
        we = 1'b1; drv = 32'h00000006; drv_en = 1'b1;
        @(posedge clk); #1;
        we = 1'b0; oe = 1'b1; drv_en = 1'b0;
        sb.push_back('{"store_seq", 1'b0, 32'h00000006});

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
